// File: rtl/mdu_pkg.sv
// Shared op encodings and helpers for the HI/LO multiply-divide unit.
// MADD/MADDU/MSUB only count as multi-cycle when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam int MDU_W = 32;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;

  function automatic logic is_long(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: is_long = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB:          is_long = 1'b1;
`endif
      default:                                is_long = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// HI/LO multiply-divide unit: result computed at acceptance, committed after MULT_LAT/DIV_LAT cycles.
// busy stalls new MD ops (start while busy is dropped); MDU_MADD_EN adds MADD/MADDU/MSUB.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [MDU_W-1:0] rs_data,
  input  logic [MDU_W-1:0] rt_data,
  output logic             busy,
  output logic [MDU_W-1:0] hi,
  output logic [MDU_W-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [MDU_W-1:0] hi_q, hi_d;
  logic [MDU_W-1:0] lo_q, lo_d;
  logic [MDU_W-1:0] pend_hi_q, pend_hi_d;
  logic [MDU_W-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One shared multiplier; signed ops sign-extend, unsigned ops zero-extend.
  logic        mul_sgn;
  logic [63:0] mul_a, mul_b, prod;

  assign mul_sgn = (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
  assign mul_a   = {{MDU_W{mul_sgn & rs_data[MDU_W-1]}}, rs_data};
  assign mul_b   = {{MDU_W{mul_sgn & rt_data[MDU_W-1]}}, rt_data};
  assign prod    = mul_a * mul_b;

  // Sign-magnitude divide: 0x80000000 / -1 falls out as lo=0x80000000, hi=0.
  logic             div_sgn, op_is_div;
  logic             a_neg, b_neg;
  logic [MDU_W-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign op_is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  assign div_sgn   = (op == MDU_DIV);
  assign a_neg     = div_sgn & rs_data[MDU_W-1];
  assign b_neg     = div_sgn & rt_data[MDU_W-1];
  assign a_mag     = a_neg ? -rs_data : rs_data;
  assign b_mag     = b_neg ? -rt_data : rt_data;
  assign b_safe    = (b_mag == '0) ? {{(MDU_W-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag     = a_mag / b_safe;
  assign r_mag     = a_mag % b_safe;
  assign quo       = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem       = a_neg ? -r_mag : r_mag;

`ifdef MDU_MADD_EN
  logic [63:0] acc_sum;
  assign acc_sum = (op == MDU_MSUB) ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    cnt_d     = cnt_q;

    if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        pend_wr_d = 1'b0;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end else if (start) begin
      if (is_long(op)) begin
        cnt_d = op_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      end
      case (op)
        MDU_MTHI: hi_d = rs_data;
        MDU_MTLO: lo_d = rs_data;
        MDU_MULT, MDU_MULTU: begin
          {pend_hi_d, pend_lo_d} = prod;
          pend_wr_d              = 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          // Divide by zero still burns the latency but never commits.
          {pend_hi_d, pend_lo_d} = {rem, quo};
          pend_wr_d              = (rt_data != '0);
        end
`ifdef MDU_MADD_EN
        MDU_MADD, MDU_MADDU, MDU_MSUB: begin
          {pend_hi_d, pend_lo_d} = acc_sum;
          pend_wr_d              = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: driver pushes model results, monitor pops on each accepted op.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [3:0]  op      = 4'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  mdu_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    int          lat;
    logic [31:0] old_hi, old_lo, exp_hi, exp_lo;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference behaviour from the architectural rules, using wide integer arithmetic.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    lat = 0;
    case (o)
      4'd1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; lat = MULT_LAT; end
      4'd2: begin p = ua * ub;      {m_hi, m_lo} = p; lat = MULT_LAT; end
      4'd3: begin
        if (b != 32'd0) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        lat = DIV_LAT;
      end
      4'd4: begin
        if (b != 32'd0) begin
          p = ua / ub; m_lo = p[31:0];
          p = ua % ub; m_hi = p[31:0];
        end
        lat = DIV_LAT;
      end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
`ifdef MDU_MADD_EN
      4'd7: begin {m_hi, m_lo} = {m_hi, m_lo} + 64'(sa * sb); lat = MULT_LAT; end
      4'd8: begin {m_hi, m_lo} = {m_hi, m_lo} + ua * ub;      lat = MULT_LAT; end
      4'd9: begin {m_hi, m_lo} = {m_hi, m_lo} - 64'(sa * sb); lat = MULT_LAT; end
`endif
      default: ;
    endcase
  endtask

  // Caller guarantees busy=0; abort_at>0 means reset will land after that many busy cycles.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int abort_at);
    exp_t it;
    int   lat;
    it.op     = o;
    it.old_hi = m_hi;
    it.old_lo = m_lo;
    model(o, a, b, lat);
    if (abort_at > 0) begin
      lat  = abort_at;
      m_hi = 32'd0;
      m_lo = 32'd0;
    end
    it.lat    = lat;
    it.exp_hi = m_hi;
    it.exp_lo = m_lo;
    sb_q.push_back(it);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", {63'd0, busy}, 64'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: rand_val = 32'd0;
      1: rand_val = 32'hFFFF_FFFF;
      2: rand_val = 32'h8000_0000;
      3: rand_val = 32'h7FFF_FFFF;
      4: rand_val = 32'($urandom_range(0, 20));
      default: rand_val = $urandom;
    endcase
  endfunction

  // Monitor: every accepted op (start && !busy before an edge) pops one expectation.
  initial begin : monitor
    exp_t it;
    int   n;
    logic hold_ok;
    forever begin
      @(negedge clk);
      if (!reset && start && !busy) begin
        @(posedge clk); #1;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_accept", 64'd1, 64'd0);
        end else begin
          it      = sb_q.pop_front();
          n       = 0;
          hold_ok = 1'b1;
          while (busy && n < 64) begin
            n++;
            if ({hi, lo} !== {it.old_hi, it.old_lo}) hold_ok = 1'b0;
            @(posedge clk); #1;
          end
          chk($sformatf("op%0d_busy_cycles", it.op), 64'(n), 64'(it.lat));
          if (it.lat > 0) chk($sformatf("op%0d_hold_during_busy", it.op), {63'd0, hold_ok}, 64'd1);
          chk($sformatf("op%0d_hilo", it.op), {hi, lo}, {it.exp_hi, it.exp_lo});
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [3:0] o;
    int         n;
    cycles(3);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    cycles(1);

    issue(MDU_MULT,  32'hFFFF_FFFD, 32'd5, 0); wait_idle();
    issue(MDU_MULTU, 32'hFFFF_FFFD, 32'd5, 0); wait_idle();
    issue(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 0); wait_idle();

    // MTHI offered while a divide-by-zero is in flight must be dropped.
    issue(MDU_DIVU, 32'd7, 32'd0, 0);
    op = MDU_MTHI; rs_data = 32'h1234_5678; start = 1'b1;
    cycles(3);
    start = 1'b0;
    wait_idle();
    issue(MDU_MTHI, 32'h1234_5678, 32'd0, 0);
    cycles(1);

    issue(MDU_MTHI, 32'd0, 32'd0, 0);
    issue(MDU_MTLO, 32'd1, 32'd0, 0);
    issue(MDU_MADD, 32'd2, 32'd3, 0); wait_idle();

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0); wait_idle();

    // Reset lands on the 4th busy cycle of a divide.
    issue(MDU_DIV, 32'd100, 32'd7, 4);
    cycles(3);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(DIV_LAT + 2);
    chk("abort_no_late_commit", {hi, lo}, 64'd0);
    chk("abort_busy_low", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 300; i++) begin
      wait_idle();
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 2));
      if ($urandom_range(0, 3) == 0) o = 4'($urandom_range(0, 15));
      else o = 4'($urandom_range(1, 6));
      issue(o, rand_val(), rand_val(), 0);
      if (busy && $urandom_range(0, 3) == 0) begin
        op = 4'($urandom_range(0, 15)); rs_data = $urandom; rt_data = $urandom;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
      end
    end
    wait_idle();

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      cycles(1);
      n++;
    end
    cycles(2);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
